// File: rtl/md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_pkg                                                               |
// | Shared types and constants for the motion-update / cell-write path.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package md_pkg;

    localparam int FP_W          = 32;
    localparam int CELL_NULL_BIT = 32;
    localparam int POS_NULL_BIT  = 96;

    // MSB is the null flag; coordinates packed z:y:x from the top down.
    typedef struct packed {
        logic            null_flag;
        logic [FP_W-1:0] z;
        logic [FP_W-1:0] y;
        logic [FP_W-1:0] x;
    } pos_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_RUN    = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage : md_pkg
`default_nettype wire

// File: rtl/cell_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cell_counter_bank                                                    |
// | Two banks of per-cell occupancy counters (0..DEPTH, saturating).     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cell_counter_bank #(
    parameter  int N_CELLS = 8,
    parameter  int DEPTH   = 16,
    localparam int CELL_W  = $clog2(N_CELLS),
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_en,
    input  logic              clr_bank,
    input  logic              inc_en,
    input  logic              inc_bank,
    input  logic [CELL_W-1:0] inc_cell,
    input  logic              q_bank,
    input  logic [CELL_W-1:0] q_cell,
    output logic [ADDR_W:0]   q_count,
    input  logic              rd_bank,
    input  logic [CELL_W-1:0] rd_cell,
    output logic [ADDR_W:0]   rd_count
);

    localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0] cnt_q [2][N_CELLS];
    logic [ADDR_W:0] cnt_d [2][N_CELLS];

    always_comb begin
        cnt_d = cnt_q;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < N_CELLS; c++) begin
                if (clr_en && (1'(b) == clr_bank)) begin
                    cnt_d[b][c] = '0;
                end else if (inc_en && (1'(b) == inc_bank) && (CELL_W'(c) == inc_cell)
                             && (cnt_q[b][c] != C_FULL)) begin
                    cnt_d[b][c] = cnt_q[b][c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < N_CELLS; c++) begin
                    cnt_q[b][c] <= '0;
                end
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_count  = cnt_q[q_bank][q_cell];
    assign rd_count = cnt_q[rd_bank][rd_cell];

endmodule : cell_counter_bank
`default_nettype wire

// File: rtl/particle_cell_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | particle_cell_writer                                                 |
// | Appends position records into per-cell slots of a double-buffered    |
// | memory and commits the filled bank at end of timestep.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module particle_cell_writer
    import md_pkg::*;
#(
    parameter  int N_CELLS = 8,
    parameter  int DEPTH   = 16,
    localparam int CELL_W  = $clog2(N_CELLS),
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32:0]       in_cell,
    input  logic [96:0]       in_pos,
    input  logic              in_last,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [CELL_W-1:0] wr_cell,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [95:0]       wr_data,
    output logic              rd_bank,
    input  logic [CELL_W-1:0] rd_cell,
    output logic [ADDR_W:0]   rd_count,
    output logic              done,
    output logic              overflow,
    output logic              bad_cell
);

    localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              overflow_q, overflow_d;
    logic              bad_cell_q, bad_cell_d;
    logic              wr_en_q, wr_en_d;
    logic [CELL_W-1:0] wr_cell_q, wr_cell_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [95:0]       wr_data_q, wr_data_d;

    logic              clr_en;
    logic              inc_en;
    logic [ADDR_W:0]   q_count;
    pos_t              pos;
    logic              rec_null;
    logic              cell_oob;

    assign pos      = pos_t'(in_pos);
    assign rec_null = in_cell[CELL_NULL_BIT] | pos.null_flag;
    assign cell_oob = (in_cell[31:0] >= 32'(N_CELLS));

    cell_counter_bank #(
        .N_CELLS (N_CELLS),
        .DEPTH   (DEPTH)
    ) u_counters (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (clr_en),
        .clr_bank (wr_bank_q),
        .inc_en   (inc_en),
        .inc_bank (wr_bank_q),
        .inc_cell (in_cell[CELL_W-1:0]),
        .q_bank   (wr_bank_q),
        .q_cell   (in_cell[CELL_W-1:0]),
        .q_count  (q_count),
        .rd_bank  (~wr_bank_q),
        .rd_cell  (rd_cell),
        .rd_count (rd_count)
    );

    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        overflow_d = overflow_q;
        bad_cell_d = bad_cell_q;
        wr_en_d    = 1'b0;
        wr_cell_d  = wr_cell_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        clr_en     = 1'b0;
        inc_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_CLEAR;
                    overflow_d = 1'b0;
                    bad_cell_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                clr_en  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (in_valid) begin
                    if (!rec_null) begin
                        if (cell_oob) begin
                            bad_cell_d = 1'b1;
                        end else if (q_count == C_FULL) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_cell_d = in_cell[CELL_W-1:0];
                            wr_addr_d = q_count[ADDR_W-1:0];
                            wr_data_d = {pos.z, pos.y, pos.x};
                            inc_en    = 1'b1;
                        end
                    end
                    // A dropped or null record still ends the timestep.
                    if (in_last) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                wr_bank_d = ~wr_bank_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_bank_q  <= 1'b0;
            overflow_q <= 1'b0;
            bad_cell_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_cell_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            overflow_q <= overflow_d;
            bad_cell_q <= bad_cell_d;
            wr_en_q    <= wr_en_d;
            wr_cell_q  <= wr_cell_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign in_ready = (state_q == ST_RUN);
    assign done     = (state_q == ST_COMMIT);
    assign wr_en    = wr_en_q;
    assign wr_bank  = wr_bank_q;
    assign rd_bank  = ~wr_bank_q;
    assign wr_cell  = wr_cell_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign overflow = overflow_q;
    assign bad_cell = bad_cell_q;

endmodule : particle_cell_writer
`default_nettype wire

// File: tb/tb_particle_cell_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_particle_cell_writer                                              |
// | Randomised and directed checks against an array-based occupancy model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_particle_cell_writer;

    localparam int N_CELLS = 8;
    localparam int DEPTH   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_cell;
    logic [96:0] in_pos;
    logic        in_last;
    logic        wr_en;
    logic        wr_bank;
    logic [2:0]  wr_cell;
    logic [3:0]  wr_addr;
    logic [95:0] wr_data;
    logic        rd_bank;
    logic [2:0]  rd_cell;
    logic [4:0]  rd_count;
    logic        done;
    logic        overflow;
    logic        bad_cell;

    particle_cell_writer #(.N_CELLS(N_CELLS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_cell(in_cell),
        .in_pos(in_pos), .in_last(in_last),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_cell(wr_cell),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_bank(rd_bank), .rd_cell(rd_cell), .rd_count(rd_count),
        .done(done), .overflow(overflow), .bad_cell(bad_cell)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: occupancy per bank/cell, current write bank, sticky flags.
    int m_cnt [2][N_CELLS];
    int m_wbank;
    bit m_ovf;
    bit m_bad;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < N_CELLS; c++)
                m_cnt[b][c] = 0;
        m_wbank = 0;
        m_ovf   = 0;
        m_bad   = 0;
    endtask

    task automatic check_counts(input string tag);
        for (int c = 0; c < N_CELLS; c++) begin
            rd_cell = 3'(c);
            #1;
            chk(tag, rd_count, 128'(m_cnt[1 - m_wbank][c]));
        end
        rd_cell = '0;
    endtask

    function automatic logic [96:0] mkpos(input bit pnull, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] z);
        return {pnull, z, y, x};
    endfunction

    // Begin a timestep; keeps in_valid high so records during IDLE/CLEAR must be ignored.
    task automatic start_fill();
        start    = 1'b1;
        in_valid = 1'b1;
        in_cell  = 33'd0;
        in_pos   = mkpos(0, 32'h1, 32'h2, 32'h3);
        in_last  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_ovf = 0;
        m_bad = 0;
        for (int c = 0; c < N_CELLS; c++) m_cnt[m_wbank][c] = 0;
        chk("clear_ready", in_ready, 0);
        chk("clear_wr_en", wr_en, 0);
        chk("clear_ovf", overflow, 0);
        chk("clear_bad", bad_cell, 0);
        @(posedge clk); #1;
        chk("run_ready", in_ready, 1);
        chk("run_wr_en", wr_en, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // One cycle of the RUN phase; v=0 is an idle gap.
    task automatic beat(input bit v, input logic [32:0] c, input logic [96:0] p, input bit last);
        bit        exp_we;
        int        exp_addr;
        longint    cidx;
        in_valid = v;
        in_cell  = c;
        in_pos   = p;
        in_last  = last;
        @(posedge clk); #1;
        exp_we   = 0;
        exp_addr = 0;
        cidx     = longint'(c[31:0]);
        if (v && !c[32] && !p[96]) begin
            if (cidx >= N_CELLS) m_bad = 1;
            else if (m_cnt[m_wbank][cidx] == DEPTH) m_ovf = 1;
            else begin
                exp_we   = 1;
                exp_addr = m_cnt[m_wbank][cidx];
                m_cnt[m_wbank][cidx]++;
            end
        end
        chk("wr_en", wr_en, 128'(exp_we));
        if (exp_we) begin
            chk("wr_cell", wr_cell, 128'(cidx));
            chk("wr_addr", wr_addr, 128'(exp_addr));
            chk("wr_data", wr_data, 128'(p[95:0]));
            chk("wr_bank", wr_bank, 128'(m_wbank));
        end
        chk("done", done, 128'(v && last));
        chk("overflow", overflow, 128'(m_ovf));
        chk("bad_cell", bad_cell, 128'(m_bad));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_commit();
        @(posedge clk); #1;
        m_wbank = 1 - m_wbank;
        chk("post_done", done, 0);
        chk("post_ready", in_ready, 0);
        chk("post_wr_bank", wr_bank, 128'(m_wbank));
        chk("post_rd_bank", rd_bank, 128'(1 - m_wbank));
        chk("post_ovf", overflow, 128'(m_ovf));
        chk("post_bad", bad_cell, 128'(m_bad));
        check_counts("rd_count");
    endtask

    task automatic random_fill(input int nbeats);
        logic [32:0] c;
        logic [96:0] p;
        int          r;
        start_fill();
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0)
                beat(0, 33'($urandom), mkpos(0, $urandom, $urandom, $urandom), 1);
            r = $urandom_range(0, 19);
            if (r < 16)      c = 33'(r % 4);
            else if (r < 18) c = 33'(N_CELLS + $urandom_range(0, 100));
            else             c = {1'b0, 32'($urandom)};
            if ($urandom_range(0, 19) == 0) c[32] = 1'b1;
            p = mkpos($urandom_range(0, 19) == 0, $urandom, $urandom, $urandom);
            beat(1, c, p, i == nbeats - 1);
        end
        finish_commit();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_cell = '0;
        in_pos = '0; in_last = 1'b0; rd_cell = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_bad", bad_cell, 0);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_rd_bank", rd_bank, 1);
        chk("rst_wr_cell", wr_cell, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        check_counts("rst_rd_count");

        // Three records to cell 2, x = 1.0
        start_fill();
        for (int i = 0; i < 3; i++)
            beat(1, 33'd2, mkpos(0, 32'h3f800000, 32'h0, 32'h0), i == 2);
        finish_commit();
        chk("t1_rd_bank", rd_bank, 0);

        // Null position between two cell-5 records
        start_fill();
        beat(1, 33'd5, mkpos(0, 32'h40000000, 32'h1, 32'h2), 0);
        beat(1, 33'd5, mkpos(1, 32'h40400000, 32'h3, 32'h4), 0);
        beat(1, 33'd5, mkpos(0, 32'h40800000, 32'h5, 32'h6), 1);
        finish_commit();

        // Cell 0 overflow
        start_fill();
        for (int i = 0; i < 17; i++)
            beat(1, 33'd0, mkpos(0, 32'(i), 32'h0, 32'hbf800000), i == 16);
        finish_commit();

        // Out-of-range cell followed by a valid record; sticky flags clear from prior fill
        start_fill();
        beat(1, 33'd9, mkpos(0, 32'h1, 32'h1, 32'h1), 0);
        beat(1, 33'd1, mkpos(0, 32'h2, 32'h2, 32'h2), 0);
        beat(1, 33'd9, mkpos(0, 32'h3, 32'h3, 32'h3), 1);
        finish_commit();

        for (int t = 0; t < 6; t++)
            random_fill($urandom_range(1, 40));

        // Reset mid-fill discards the partial bank
        start_fill();
        for (int i = 0; i < 4; i++)
            beat(1, 33'($urandom_range(0, 7)), mkpos(0, $urandom, $urandom, $urandom), 0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_cell  = 33'd3;
        in_last  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_reset();
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_rd_bank", rd_bank, 1);
        check_counts("mid_rst_rd_count");
        @(posedge clk); #1;
        chk("mid_rst_done2", done, 0);

        // Refill after reset starts at address 0
        start_fill();
        for (int i = 0; i < 4; i++)
            beat(1, 33'd3, mkpos(0, 32'(i + 100), 32'h7, 32'h8), i == 3);
        finish_commit();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_particle_cell_writer
`default_nettype wire
